// File: rtl/pe_array_if_pipe_pkg.sv
// pe_array_if_pipe_pkg: field defaults, bypass window and per-cycle action codes shared by the IF and ID stages
package pe_array_if_pipe_pkg;
  localparam int DEF_INS_W      = 24;
  localparam int DEF_RF_IDX_W   = 5;
  localparam int DEF_BP_SEL_W   = 2;
  localparam int DEF_SRC1_LSB   = 8;
  localparam int DEF_SRC2_LSB   = 3;
  localparam int DEF_TYPE_BIT   = 23;
  localparam int DEF_I_TYPE_VAL = 1;
  localparam int DEF_DSEL_W     = 3;
  localparam int DEF_PRED_W     = 2;
  localparam int DEF_CNT_W      = 16;
  typedef enum logic [2:0] {ACT_FLUSH, ACT_SKD, ACT_IN, ACT_DRAIN, ACT_STALL} if_act_e;
endpackage

// File: rtl/pe_array_if_pipe_if.sv
// pe_array_if_pipe_if: IMEM-side handshake and ID-side bundle of the IF stage
interface pe_array_if_pipe_if import pe_array_if_pipe_pkg::*; #(
  parameter int INS_W    = DEF_INS_W,
  parameter int RF_IDX_W = DEF_RF_IDX_W,
  parameter int BP_SEL_W = DEF_BP_SEL_W,
  parameter int DSEL_W   = DEF_DSEL_W,
  parameter int PRED_W   = DEF_PRED_W,
  parameter int CNT_W    = DEF_CNT_W
);
  logic                iIMEM_Valid;
  logic [INS_W-1:0]    iIMEM_IF_Instruction;
  logic [DSEL_W-1:0]   iData_Selection;
  logic [PRED_W-1:0]   iPredication;
  logic                oIF_IMEM_Ready;
  logic                iID_Stall;
  logic                iFlush;
  logic                oIF_ID_Valid;
  logic [INS_W-1:0]    oIF_ID_Instruction;
  logic [PRED_W-1:0]   oPredication;
  logic [DSEL_W-1:0]   oIF_BP_Data_Selection;
  logic [RF_IDX_W-1:0] oIF_RF_Read_Addr_A;
  logic [RF_IDX_W-1:0] oIF_RF_Read_Addr_B;
  logic                oIF_BP_Bypass_Read_A;
  logic                oIF_BP_Bypass_Read_B;
  logic [BP_SEL_W-1:0] oIF_BP_Bypass_Sel_A;
  logic [BP_SEL_W-1:0] oIF_BP_Bypass_Sel_B;
  logic                oIF_BP_Select_Imm;
  logic [CNT_W-1:0]    oIF_Stall_Count;
  modport master (
    output iIMEM_Valid, iIMEM_IF_Instruction, iData_Selection, iPredication, iID_Stall, iFlush,
    input  oIF_IMEM_Ready, oIF_ID_Valid, oIF_ID_Instruction, oPredication, oIF_BP_Data_Selection,
           oIF_RF_Read_Addr_A, oIF_RF_Read_Addr_B, oIF_BP_Bypass_Read_A, oIF_BP_Bypass_Read_B,
           oIF_BP_Bypass_Sel_A, oIF_BP_Bypass_Sel_B, oIF_BP_Select_Imm, oIF_Stall_Count
  );
  modport slave (
    input  iIMEM_Valid, iIMEM_IF_Instruction, iData_Selection, iPredication, iID_Stall, iFlush,
    output oIF_IMEM_Ready, oIF_ID_Valid, oIF_ID_Instruction, oPredication, oIF_BP_Data_Selection,
           oIF_RF_Read_Addr_A, oIF_RF_Read_Addr_B, oIF_BP_Bypass_Read_A, oIF_BP_Bypass_Read_B,
           oIF_BP_Bypass_Sel_A, oIF_BP_Bypass_Sel_B, oIF_BP_Select_Imm, oIF_Stall_Count
  );
endinterface

// File: rtl/pe_if_predecode.sv
// pe_if_predecode: combinational extraction of RF sources, bypass-window hits and immediate select
module pe_if_predecode import pe_array_if_pipe_pkg::*; #(
  parameter int INS_W      = DEF_INS_W,
  parameter int RF_IDX_W   = DEF_RF_IDX_W,
  parameter int BP_SEL_W   = DEF_BP_SEL_W,
  parameter int SRC1_LSB   = DEF_SRC1_LSB,
  parameter int SRC2_LSB   = DEF_SRC2_LSB,
  parameter int TYPE_BIT   = DEF_TYPE_BIT,
  parameter int I_TYPE_VAL = DEF_I_TYPE_VAL
) (
  input  logic [INS_W-1:0]    instruction,
  output logic [RF_IDX_W-1:0] srcA,
  output logic [RF_IDX_W-1:0] srcB,
  output logic                bypassA,
  output logic                bypassB,
  output logic                selectImm
);
  assign srcA      = instruction[SRC1_LSB +: RF_IDX_W];
  assign srcB      = instruction[SRC2_LSB +: RF_IDX_W];
  assign bypassA   = &srcA[RF_IDX_W-1:BP_SEL_W];
  assign bypassB   = &srcB[RF_IDX_W-1:BP_SEL_W];
  assign selectImm = instruction[TYPE_BIT] == 1'(I_TYPE_VAL);
endmodule

// File: rtl/pe_array_if_pipe.sv
// pe_array_if_pipe: IF stage with IMEM handshake, 2-entry skid buffer, pre-decode and stall counter
module pe_array_if_pipe import pe_array_if_pipe_pkg::*; #(
  parameter int INS_W      = DEF_INS_W,
  parameter int RF_IDX_W   = DEF_RF_IDX_W,
  parameter int BP_SEL_W   = DEF_BP_SEL_W,
  parameter int SRC1_LSB   = DEF_SRC1_LSB,
  parameter int SRC2_LSB   = DEF_SRC2_LSB,
  parameter int TYPE_BIT   = DEF_TYPE_BIT,
  parameter int I_TYPE_VAL = DEF_I_TYPE_VAL,
  parameter int DSEL_W     = DEF_DSEL_W,
  parameter int PRED_W     = DEF_PRED_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic iClk,
  input logic iReset,
  pe_array_if_pipe_if.slave bus
);
  if (BP_SEL_W >= RF_IDX_W || SRC1_LSB + RF_IDX_W > INS_W || SRC2_LSB + RF_IDX_W > INS_W || TYPE_BIT >= INS_W) begin : g_bad_params
    $error("pe_array_if_pipe: illegal field layout");
  end
  logic                outValid, skdValid, rdy, skdNext, load, skdLoad, accept;
  logic [INS_W-1:0]    skdIns, ldIns, outIns;
  logic [DSEL_W-1:0]   skdDsel, ldDsel, outDsel;
  logic [PRED_W-1:0]   skdPred, ldPred, outPred;
  logic [RF_IDX_W-1:0] srcA, srcB, addrA, addrB;
  logic [BP_SEL_W-1:0] selA, selB;
  logic                dBypA, dBypB, dImm, bypA, bypB, imm;
  logic [CNT_W-1:0]    cnt;
  if_act_e             act;
  assign accept = bus.iIMEM_Valid & rdy;
  assign act = bus.iFlush ? ACT_FLUSH :
               (!outValid || !bus.iID_Stall) ? (skdValid ? ACT_SKD : accept ? ACT_IN : ACT_DRAIN) :
               ACT_STALL;
  assign load    = act == ACT_SKD || act == ACT_IN;
  assign skdLoad = accept && (act == ACT_SKD || act == ACT_STALL);
  assign skdNext = act == ACT_SKD ? accept : act == ACT_STALL ? (skdValid | accept) : 1'b0;
  // The skid entry is always older than the incoming word, so it wins the OUT slot
  assign ldIns  = skdValid ? skdIns : bus.iIMEM_IF_Instruction;
  assign ldDsel = skdValid ? skdDsel : bus.iData_Selection;
  assign ldPred = skdValid ? skdPred : bus.iPredication;
  pe_if_predecode #(
    .INS_W(INS_W), .RF_IDX_W(RF_IDX_W), .BP_SEL_W(BP_SEL_W), .SRC1_LSB(SRC1_LSB),
    .SRC2_LSB(SRC2_LSB), .TYPE_BIT(TYPE_BIT), .I_TYPE_VAL(I_TYPE_VAL)
  ) predecode (
    .instruction(ldIns), .srcA(srcA), .srcB(srcB),
    .bypassA(dBypA), .bypassB(dBypB), .selectImm(dImm)
  );
  always_ff @(posedge iClk) begin
    if (iReset) begin
      {outValid, skdValid, skdIns, skdDsel, skdPred, outIns, outDsel, outPred} <= '0;
      {addrA, addrB, selA, selB, bypA, bypB, imm, cnt} <= '0;
      rdy <= 1'b1;
    end else begin
      outValid <= load || act == ACT_STALL;
      skdValid <= skdNext;
      rdy      <= ~skdNext;
      if (skdLoad) begin
        skdIns  <= bus.iIMEM_IF_Instruction;
        skdDsel <= bus.iData_Selection;
        skdPred <= bus.iPredication;
      end
      if (load) begin
        outIns  <= ldIns;
        outDsel <= ldDsel;
        outPred <= ldPred;
        bypA    <= dBypA;
        bypB    <= dBypB;
        imm     <= dImm;
        // Sticky: the unused one of address/select keeps its value to avoid RF read toggling
        if (dBypA) selA <= srcA[BP_SEL_W-1:0];
        else addrA <= srcA;
        if (dBypB) selB <= srcB[BP_SEL_W-1:0];
        else addrB <= srcB;
      end
      if (outValid && bus.iID_Stall && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
  assign bus.oIF_IMEM_Ready        = rdy;
  assign bus.oIF_ID_Valid          = outValid;
  assign bus.oIF_ID_Instruction    = outIns;
  assign bus.oPredication          = outPred;
  assign bus.oIF_BP_Data_Selection = outDsel;
  assign bus.oIF_RF_Read_Addr_A    = addrA;
  assign bus.oIF_RF_Read_Addr_B    = addrB;
  assign bus.oIF_BP_Bypass_Read_A  = bypA;
  assign bus.oIF_BP_Bypass_Read_B  = bypB;
  assign bus.oIF_BP_Bypass_Sel_A   = selA;
  assign bus.oIF_BP_Bypass_Sel_B   = selB;
  assign bus.oIF_BP_Select_Imm     = imm;
  assign bus.oIF_Stall_Count       = cnt;
endmodule

// File: tb/tb_pe_array_if_pipe.sv
// tb_pe_array_if_pipe: table vectors plus scoreboard for the IF stage, with stall/flush/saturation sequences
module tb_pe_array_if_pipe;
  import pe_array_if_pipe_pkg::*;
  localparam int CW = 4;
  typedef struct packed {
    logic [23:0] ins;
    logic [2:0]  dsel;
    logic [1:0]  pred;
    logic [4:0]  addrA;
    logic [4:0]  addrB;
    logic        bypA;
    logic        bypB;
    logic [1:0]  selA;
    logic [1:0]  selB;
    logic        imm;
  } rec_t;
  logic iClk = 1'b0;
  logic iReset = 1'b1;
  always #5 iClk = ~iClk;
  pe_array_if_pipe_if #(.CNT_W(CW)) bus ();
  pe_array_if_pipe #(.CNT_W(CW)) dut (.iClk(iClk), .iReset(iReset), .bus(bus));
  rec_t sbq[$];
  rec_t tbl[8];
  int nVec = 0;
  int nErr = 0;
  logic [4:0] stA = '0, stB = '0;
  logic [1:0] stSA = '0, stSB = '0;
  logic [CW-1:0] cntExp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t dutRec();
    rec_t r;
    r.ins   = bus.oIF_ID_Instruction;
    r.dsel  = bus.oIF_BP_Data_Selection;
    r.pred  = bus.oPredication;
    r.addrA = bus.oIF_RF_Read_Addr_A;
    r.addrB = bus.oIF_RF_Read_Addr_B;
    r.bypA  = bus.oIF_BP_Bypass_Read_A;
    r.bypB  = bus.oIF_BP_Bypass_Read_B;
    r.selA  = bus.oIF_BP_Bypass_Sel_A;
    r.selB  = bus.oIF_BP_Bypass_Sel_B;
    r.imm   = bus.oIF_BP_Select_Imm;
    return r;
  endfunction

  function automatic rec_t predict(input logic [23:0] w, input logic [2:0] d, input logic [1:0] p);
    rec_t r;
    logic [4:0] a, b;
    a = w[12:8];
    b = w[7:3];
    r.ins   = w;
    r.dsel  = d;
    r.pred  = p;
    r.imm   = w[23];
    r.bypA  = a >= 5'd28;
    r.bypB  = b >= 5'd28;
    r.addrA = r.bypA ? stA : a;
    r.addrB = r.bypB ? stB : b;
    r.selA  = r.bypA ? a[1:0] : stSA;
    r.selB  = r.bypB ? b[1:0] : stSB;
    return r;
  endfunction

  // Scoreboard: push on accept, pop on consume; flush/reset drop everything pending
  initial begin
    rec_t r;
    forever begin
      @(negedge iClk);
      if (iReset) begin
        sbq.delete();
        {stA, stB, stSA, stSB} = '0;
        cntExp = '0;
      end else begin
        chk("stall_count", 64'(bus.oIF_Stall_Count), 64'(cntExp));
        if (!bus.iFlush && bus.oIF_ID_Valid && !bus.iID_Stall) begin
          if (sbq.size() == 0) begin
            nVec++;
            nErr++;
            $display("FAIL sb_extra: got %0h with nothing expected", dutRec());
          end else chk("sb_out", 64'(dutRec()), 64'(sbq.pop_front()));
        end
        if (bus.iFlush) sbq.delete();
        else if (bus.iIMEM_Valid && bus.oIF_IMEM_Ready) begin
          r = predict(bus.iIMEM_IF_Instruction, bus.iData_Selection, bus.iPredication);
          sbq.push_back(r);
          {stA, stB, stSA, stSB} = {r.addrA, r.addrB, r.selA, r.selB};
        end
        if (bus.oIF_ID_Valid && bus.iID_Stall && cntExp != '1) cntExp = cntExp + 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] w, input logic [2:0] d, input logic [1:0] p,
                       input logic st, input logic fl);
    bus.iIMEM_Valid          = v;
    bus.iIMEM_IF_Instruction = w;
    bus.iData_Selection      = d;
    bus.iPredication         = p;
    bus.iID_Stall            = st;
    bus.iFlush               = fl;
  endtask

  task automatic doReset();
    iReset = 1'b1;
    drive(0, '0, '0, '0, 0, 0);
    step();
    step();
    iReset = 1'b0;
  endtask

  initial begin
    drive(0, '0, '0, '0, 0, 0);
    tbl[0] = '{24'h000823, 3'd1, 2'd1, 5'd8,  5'd4,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[1] = '{24'h001144, 3'd2, 2'd2, 5'd17, 5'd8,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[2] = '{24'h002265, 3'd3, 2'd3, 5'd2,  5'd12, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[3] = '{24'h000708, 3'd4, 2'd0, 5'd7,  5'd1,  1'b0, 1'b0, 2'd0, 2'd0, 1'b0};
    tbl[4] = '{24'h801EE8, 3'd5, 2'd1, 5'd7,  5'd1,  1'b1, 1'b1, 2'd2, 2'd1, 1'b1};
    tbl[5] = '{24'h000000, 3'd6, 2'd2, 5'd0,  5'd0,  1'b0, 1'b0, 2'd2, 2'd1, 1'b0};
    tbl[6] = '{24'h801FE0, 3'd7, 2'd3, 5'd0,  5'd0,  1'b1, 1'b1, 2'd3, 2'd0, 1'b1};
    tbl[7] = '{24'h7F00FF, 3'd0, 2'd0, 5'd0,  5'd0,  1'b0, 1'b1, 2'd3, 2'd3, 1'b0};
    doReset();
    chk("rst_fields", 64'(dutRec()), 64'd0);
    chk("rst_valid", 64'(bus.oIF_ID_Valid), 64'd0);
    chk("rst_ready", 64'(bus.oIF_IMEM_Ready), 64'd1);
    chk("rst_count", 64'(bus.oIF_Stall_Count), 64'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].ins, tbl[i].dsel, tbl[i].pred, 0, 0);
      step();
      chk("tbl_valid", 64'(bus.oIF_ID_Valid), 64'd1);
      chk("tbl_out", 64'(dutRec()), 64'(tbl[i]));
    end
    drive(0, '0, '0, '0, 0, 0);
    step();
    chk("tbl_drain", 64'(bus.oIF_ID_Valid), 64'd0);
    // Stall 3 cycles while IMEM offers two words
    doReset();
    drive(1, 24'h0A0A51, 3'd2, 2'd1, 0, 0);
    step();
    drive(1, 24'h80B3C8, 3'd4, 2'd2, 1, 0);
    step();
    chk("skid_ready", 64'(bus.oIF_IMEM_Ready), 64'd0);
    drive(1, 24'h05C6A0, 3'd6, 2'd3, 1, 0);
    step();
    step();
    chk("stall_cnt3", 64'(bus.oIF_Stall_Count), 64'd3);
    chk("stall_hold", 64'(bus.oIF_ID_Instruction), 64'h0A0A51);
    drive(1, 24'h05C6A0, 3'd6, 2'd3, 0, 0);
    step();
    chk("rel_w2", 64'(bus.oIF_ID_Instruction), 64'h80B3C8);
    chk("rel_ready", 64'(bus.oIF_IMEM_Ready), 64'd1);
    step();
    chk("rel_w3", 64'(bus.oIF_ID_Instruction), 64'h05C6A0);
    drive(0, '0, '0, '0, 0, 0);
    step();
    chk("rel_empty", 64'(bus.oIF_ID_Valid), 64'd0);
    chk("rel_cnt", 64'(bus.oIF_Stall_Count), 64'd3);
    // Flush with both entries full and a word offered
    drive(1, 24'h112233, 3'd1, 2'd2, 0, 0);
    step();
    drive(1, 24'h445566, 3'd3, 2'd0, 1, 0);
    step();
    chk("fl_full", 64'({bus.oIF_ID_Valid, bus.oIF_IMEM_Ready}), 64'b10);
    drive(1, 24'hABCDEF, 3'd7, 2'd3, 1, 1);
    step();
    chk("fl_valid", 64'(bus.oIF_ID_Valid), 64'd0);
    chk("fl_ready", 64'(bus.oIF_IMEM_Ready), 64'd1);
    // Flush drops a word accepted in the same cycle
    drive(1, 24'h3C3C3C, 3'd5, 2'd1, 0, 1);
    step();
    chk("fl_drop", 64'(bus.oIF_ID_Valid), 64'd0);
    drive(0, '0, '0, '0, 0, 0);
    step();
    chk("fl_gone", 64'(bus.oIF_ID_Valid), 64'd0);
    drive(1, 24'h0E0C2C, 3'd2, 2'd3, 0, 0);
    step();
    chk("fl_resume", 64'({bus.oIF_ID_Valid, bus.oIF_ID_Instruction}), 64'h10E0C2C);
    drive(0, '0, '0, '0, 0, 0);
    step();
    // 20-cycle stall saturates the 4-bit counter, then reset mid-stall
    doReset();
    drive(1, 24'h012345, 3'd1, 2'd1, 0, 0);
    step();
    drive(1, 24'h067890, 3'd2, 2'd2, 1, 0);
    step();
    drive(0, '0, '0, '0, 1, 0);
    for (int i = 0; i < 19; i++) step();
    chk("sat_cnt", 64'(bus.oIF_Stall_Count), 64'd15);
    chk("sat_state", 64'({bus.oIF_ID_Valid, bus.oIF_IMEM_Ready}), 64'b10);
    iReset = 1'b1;
    step();
    chk("mid_rst_fields", 64'(dutRec()), 64'd0);
    chk("mid_rst_valid", 64'(bus.oIF_ID_Valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.oIF_IMEM_Ready), 64'd1);
    chk("mid_rst_cnt", 64'(bus.oIF_Stall_Count), 64'd0);
    iReset = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    step();
    step();
    chk("mid_rst_empty", 64'(bus.oIF_ID_Valid), 64'd0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
